fsab_master_port: RTL and testbench

// Single-client FSAB bus master: turns a simple request/write-data/read-data client interface into

---
 rtl/fsab_master_port.sv | 211 +++++++++++++++++++++
 tb/tb_fsab_master_port.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsab_master_port.sv
// FSAB single-client bus master: client req/wdat/rd ports to fsabo/fsabi.
// Tracks credits, write bursts and read-return framing via a length FIFO.
//
// Ports:
//   clk, rst_b                     clock, async active-low reset
//   req_valid/ready/write/addr/len client request handshake
//   wdat_valid/ready/data/mask     client write-data stream
//   rd_valid/data/last             read return to client
//   fsabo_*                        request beats to memory
//   fsabo_credit                   one-cycle credit return pulse
//   fsabi_valid/did/subdid/data    read return stream from memory
module fsab_master_port #(
  parameter int ADDR_W = 31,
  parameter int LEN_W = 4,
  parameter int DATA_W = 64,
  parameter int MASK_W = 8,
  parameter int DID_W = 4,
  parameter int SUBDID_W = 4,
  parameter int FSAB_INITIAL_CREDITS = 4,
  parameter int FSAB_LEN_MAX = 8,
  parameter logic [DID_W-1:0] MY_DID = '0,
  parameter logic [SUBDID_W-1:0] MY_SUBDID = '0
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [LEN_W-1:0]    req_len,
  input  logic                wdat_valid,
  output logic                wdat_ready,
  input  logic [DATA_W-1:0]   wdat_data,
  input  logic [MASK_W-1:0]   wdat_mask,
  output logic                rd_valid,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_last,
  output logic                fsabo_valid,
  output logic                fsabo_mode,
  output logic [DID_W-1:0]    fsabo_did,
  output logic [SUBDID_W-1:0] fsabo_subdid,
  output logic [ADDR_W-1:0]   fsabo_addr,
  output logic [LEN_W-1:0]    fsabo_len,
  output logic [DATA_W-1:0]   fsabo_data,
  output logic [MASK_W-1:0]   fsabo_mask,
  input  logic                fsabo_credit,
  input  logic                fsabi_valid,
  input  logic [DID_W-1:0]    fsabi_did,
  input  logic [SUBDID_W-1:0] fsabi_subdid,
  input  logic [DATA_W-1:0]   fsabi_data
);

  localparam int CW = $clog2(FSAB_INITIAL_CREDITS + 1);
  localparam int PW =
    (FSAB_INITIAL_CREDITS > 1) ? $clog2(FSAB_INITIAL_CREDITS) : 1;
  localparam logic [CW-1:0] CRED_MAX = CW'(FSAB_INITIAL_CREDITS);
  localparam logic [PW-1:0] PTR_MAX = PW'(FSAB_INITIAL_CREDITS - 1);
  localparam logic FSAB_READ = 1'b0;
  localparam logic FSAB_WRITE = 1'b1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WBURST = 1'b1;

  logic [0:0]       state;
  logic [LEN_W-1:0] rem;
  logic [CW-1:0]    credits;
  logic [LEN_W-1:0] lenfifo [FSAB_INITIAL_CREDITS];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    fcnt;
  logic [LEN_W-1:0] rd_cnt;

  logic full;
  logic empty;
  logic acc;
  logic push;
  logic pop;
  logic match;
  logic is_last;

  assign full = (fcnt == CRED_MAX);
  assign empty = (fcnt == '0);
  assign acc = req_valid && req_ready;
  assign push = acc && !req_write;
  assign match = fsabi_valid && (fsabi_did == MY_DID) &&
                 (fsabi_subdid == MY_SUBDID);
  assign is_last = ((rd_cnt + LEN_W'(1)) == lenfifo[rptr]);
  assign pop = match && !empty && is_last;

  // Ready outputs are forced low while reset is asserted.
  always_comb begin
    req_ready = 1'b0;
    wdat_ready = 1'b0;
    if (rst_b) begin
      unique case (state)
        IDLE: begin
          req_ready = (credits != '0) && !full &&
                      (!req_write || wdat_valid);
          wdat_ready = req_valid && req_ready && req_write;
        end
        default: wdat_ready = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= IDLE;
      rem <= '0;
      fsabo_valid <= 1'b0;
      fsabo_mode <= 1'b0;
      fsabo_did <= '0;
      fsabo_subdid <= '0;
      fsabo_addr <= '0;
      fsabo_len <= '0;
      fsabo_data <= '0;
      fsabo_mask <= '0;
    end else begin
      fsabo_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (acc) begin
            fsabo_valid <= 1'b1;
            fsabo_mode <= req_write ? FSAB_WRITE : FSAB_READ;
            fsabo_did <= MY_DID;
            fsabo_subdid <= MY_SUBDID;
            fsabo_addr <= req_addr;
            fsabo_len <= req_len;
            fsabo_data <= req_write ? wdat_data : '0;
            fsabo_mask <= req_write ? wdat_mask : '0;
            if (req_write && req_len > LEN_W'(1)) begin
              state <= WBURST;
              rem <= req_len - LEN_W'(1);
            end
          end
        end
        default: begin
          // Header fields hold; only data/mask advance.
          if (wdat_valid) begin
            fsabo_valid <= 1'b1;
            fsabo_data <= wdat_data;
            fsabo_mask <= wdat_mask;
            rem <= rem - LEN_W'(1);
            if (rem == LEN_W'(1)) state <= IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      credits <= CRED_MAX;
    end else if (acc && !fsabo_credit) begin
      credits <= credits - CW'(1);
    end else if (!acc && fsabo_credit && credits != CRED_MAX) begin
      credits <= credits + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wptr <= '0;
      rptr <= '0;
      fcnt <= '0;
      for (int i = 0; i < FSAB_INITIAL_CREDITS; i++) lenfifo[i] <= '0;
    end else begin
      if (push) begin
        lenfifo[wptr] <= req_len;
        wptr <= (wptr == PTR_MAX) ? '0 : wptr + PW'(1);
      end
      if (pop) rptr <= (rptr == PTR_MAX) ? '0 : rptr + PW'(1);
      unique case ({push, pop})
        2'b10: fcnt <= fcnt + CW'(1);
        2'b01: fcnt <= fcnt - CW'(1);
        default: fcnt <= fcnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rd_valid <= 1'b0;
      rd_data <= '0;
      rd_last <= 1'b0;
      rd_cnt <= '0;
    end else begin
      rd_valid <= 1'b0;
      rd_last <= 1'b0;
      if (match && !empty) begin
        rd_valid <= 1'b1;
        rd_data <= fsabi_data;
        rd_last <= is_last;
        rd_cnt <= is_last ? '0 : rd_cnt + LEN_W'(1);
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_b) begin
      if (fsabo_credit && !acc && credits == CRED_MAX)
        $error("fsab_master_port: credit return at full count");
      if (acc && (req_len == '0 || req_len > LEN_W'(FSAB_LEN_MAX)))
        $error("fsab_master_port: illegal req_len %0d", req_len);
      if (match && empty)
        $error("fsab_master_port: read return with no outstanding read");
    end
  end
`endif

endmodule

// File: tb/tb_fsab_master_port.sv
// Scoreboard bench for fsab_master_port: expected fsabo beats and rd words
// are queued when stimulus is driven and compared when the DUT emits them.
module tb_fsab_master_port;

  typedef struct {
    logic        mode;
    logic [30:0] addr;
    logic [3:0]  len;
    logic [63:0] data;
    logic [7:0]  mask;
  } beat_t;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } rd_t;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [30:0] req_addr = '0;
  logic [3:0]  req_len = '0;
  logic        wdat_valid = 1'b0;
  logic        wdat_ready;
  logic [63:0] wdat_data = '0;
  logic [7:0]  wdat_mask = '0;
  logic        rd_valid;
  logic [63:0] rd_data;
  logic        rd_last;
  logic        fsabo_valid;
  logic        fsabo_mode;
  logic [3:0]  fsabo_did;
  logic [3:0]  fsabo_subdid;
  logic [30:0] fsabo_addr;
  logic [3:0]  fsabo_len;
  logic [63:0] fsabo_data;
  logic [7:0]  fsabo_mask;
  logic        fsabo_credit = 1'b0;
  logic        fsabi_valid = 1'b0;
  logic [3:0]  fsabi_did = '0;
  logic [3:0]  fsabi_subdid = '0;
  logic [63:0] fsabi_data = '0;

  localparam logic [3:0] DID = 4'h3;
  localparam logic [3:0] SUB = 4'h1;

  int n_tests = 0;
  int n_fail = 0;
  beat_t beat_q[$];
  rd_t rd_q[$];
  int len_q[$];
  int rcnt = 0;

  fsab_master_port #(
    .MY_DID(DID),
    .MY_SUBDID(SUB)
  ) dut (
    .clk(clk),
    .rst_b(rst_b),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_len(req_len),
    .wdat_valid(wdat_valid),
    .wdat_ready(wdat_ready),
    .wdat_data(wdat_data),
    .wdat_mask(wdat_mask),
    .rd_valid(rd_valid),
    .rd_data(rd_data),
    .rd_last(rd_last),
    .fsabo_valid(fsabo_valid),
    .fsabo_mode(fsabo_mode),
    .fsabo_did(fsabo_did),
    .fsabo_subdid(fsabo_subdid),
    .fsabo_addr(fsabo_addr),
    .fsabo_len(fsabo_len),
    .fsabo_data(fsabo_data),
    .fsabo_mask(fsabo_mask),
    .fsabo_credit(fsabo_credit),
    .fsabi_valid(fsabi_valid),
    .fsabi_did(fsabi_did),
    .fsabi_subdid(fsabi_subdid),
    .fsabi_data(fsabi_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_beat(input logic w, input logic [30:0] a,
                           input logic [3:0] l, input logic [63:0] d,
                           input logic [7:0] m);
    beat_t b;
    b.mode = w;
    b.addr = a;
    b.len = l;
    b.data = d;
    b.mask = m;
    beat_q.push_back(b);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic w, input logic [30:0] a,
                       input logic [3:0] l, input logic [63:0] d,
                       input logic [7:0] m, output int waited);
    int n = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr = a;
    req_len = l;
    if (w) begin
      wdat_valid = 1'b1;
      wdat_data = d;
      wdat_mask = m;
    end
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_accept", n < 20, 1'b1);
    if (n < 20) begin
      if (w) check("wdat_first", wdat_ready, 1'b1);
      push_beat(w, a, l, w ? d : 64'h0, w ? m : 8'h0);
      if (!w) len_q.push_back(int'(l));
    end
    waited = n;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wdat_valid = 1'b0;
  endtask

  task automatic ret(input logic [3:0] did, input logic [3:0] sub,
                     input logic [63:0] d);
    rd_t r;
    fsabi_valid = 1'b1;
    fsabi_did = did;
    fsabi_subdid = sub;
    fsabi_data = d;
    if (did == DID && sub == SUB && len_q.size() > 0) begin
      rcnt++;
      r.data = d;
      r.last = (rcnt == len_q[0]);
      if (r.last) begin
        void'(len_q.pop_front());
        rcnt = 0;
      end
      rd_q.push_back(r);
    end
    @(posedge clk);
    #1;
    fsabi_valid = 1'b0;
  endtask

  task automatic credit();
    fsabo_credit = 1'b1;
    @(posedge clk);
    #1;
    fsabo_credit = 1'b0;
  endtask

  always @(negedge clk) begin : mon
    beat_t b;
    rd_t r;
    if (rst_b) begin
      if (fsabo_valid) begin
        if (beat_q.size() == 0) begin
          check("fsabo_extra", 1'b1, 1'b0);
        end else begin
          b = beat_q.pop_front();
          check("fsabo_mode", fsabo_mode, b.mode);
          check("fsabo_addr", fsabo_addr, b.addr);
          check("fsabo_len", fsabo_len, b.len);
          check("fsabo_data", fsabo_data, b.data);
          check("fsabo_mask", fsabo_mask, b.mask);
          check("fsabo_did", {fsabo_did, fsabo_subdid}, {DID, SUB});
        end
      end
      if (rd_valid) begin
        if (rd_q.size() == 0) begin
          check("rd_extra", 1'b1, 1'b0);
        end else begin
          r = rd_q.pop_front();
          check("rd_data", rd_data, r.data);
          check("rd_last", rd_last, r.last);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    logic [63:0] d [4];

    // Reset with a request pending; nothing may be offered or emitted.
    req_valid = 1'b1;
    req_write = 1'b1;
    wdat_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_req_ready", req_ready, 1'b0);
      check("rst_wdat_ready", wdat_ready, 1'b0);
      check("rst_outs", {fsabo_valid, fsabo_mode, fsabo_addr, rd_valid,
                         rd_last}, '0);
      check("rst_data", {fsabo_data, rd_data}, '0);
    end
    req_valid = 1'b0;
    req_write = 1'b0;
    wdat_valid = 1'b0;
    rst_b = 1'b1;
    @(posedge clk);
    #1;

    // Read len 4 at 0x100, returned in order.
    issue(1'b0, 31'h100, 4'd4, 64'h0, 8'h0, w);
    check("first_ready", w, 0);
    for (int i = 0; i < 4; i++) ret(DID, SUB, {32'hDEAD0000 + i, $urandom});
    credit();

    // Write len 3 with a wdat gap after word 1.
    for (int i = 0; i < 3; i++) d[i] = {$urandom, $urandom};
    issue(1'b1, 31'h200, 4'd3, d[0], 8'hFF, w);
    push_beat(1'b1, 31'h200, 4'd3, d[1], 8'h0F);
    wdat_valid = 1'b1;
    wdat_data = d[1];
    wdat_mask = 8'h0F;
    @(negedge clk);
    check("wburst_ready", wdat_ready, 1'b1);
    check("wburst_no_req", req_ready, 1'b0);
    @(posedge clk);
    #1;
    wdat_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("wburst_bubble", fsabo_valid, 1'b0);
    push_beat(1'b1, 31'h200, 4'd3, d[2], 8'hA5);
    wdat_valid = 1'b1;
    wdat_data = d[2];
    wdat_mask = 8'hA5;
    @(posedge clk);
    #1;
    wdat_valid = 1'b0;
    @(negedge clk);
    check("wburst_idle", wdat_ready, 1'b0);
    @(posedge clk);
    #1;
    credit();

    // Exhaust credits, drain reads, then one credit pulse admits a read.
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 31'h400 + 31'(i * 8), 4'd1, 64'h0, 8'h0, w);
      check("b2b_read", w, 0);
    end
    for (int i = 0; i < 4; i++) ret(DID, SUB, {$urandom, $urandom});
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr = 31'h500;
    req_len = 4'd1;
    fsabo_credit = 1'b1;
    @(negedge clk);
    check("no_credit", req_ready, 1'b0);
    @(posedge clk);
    #1;
    fsabo_credit = 1'b0;
    issue(1'b0, 31'h500, 4'd1, 64'h0, 8'h0, w);
    check("credit_lat", w, 0);
    ret(DID, SUB, {$urandom, $urandom});

    // Credit pulse coincident with acceptance at credits==1.
    credit();
    fsabo_credit = 1'b1;
    issue(1'b0, 31'h600, 4'd2, 64'h0, 8'h0, w);
    fsabo_credit = 1'b0;
    issue(1'b0, 31'h608, 4'd1, 64'h0, 8'h0, w);
    check("coinc_ready", w, 0);
    req_valid = 1'b1;
    req_write = 1'b0;
    @(negedge clk);
    check("coinc_drain", req_ready, 1'b0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) ret(DID, SUB, {$urandom, $urandom});

    // Foreign DID/SUBDID beats interleaved with own read stream.
    repeat (4) credit();
    issue(1'b0, 31'h300, 4'd3, 64'h0, 8'h0, w);
    ret(DID, SUB, 64'h1111);
    ret(4'h5, SUB, 64'hBAD0);
    @(negedge clk);
    check("foreign_did", rd_valid, 1'b0);
    ret(DID, SUB, 64'h2222);
    ret(DID, 4'h2, 64'hBAD1);
    @(negedge clk);
    check("foreign_sub", rd_valid, 1'b0);
    ret(DID, SUB, 64'h3333);

    repeat (5) @(posedge clk);
    #1;
    check("beat_q_empty", beat_q.size(), 0);
    check("rd_q_empty", rd_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
